run_ctrl: RTL and testbench

- Hardware run controller sitting between a host/debug master and the single-cycle CPU's clock-enable.
- Accepts run commands over a valid/ready handshake and drives `cpu_en` for an exact number of cycles, one instruction per cycle.
- Stops early on a PC breakpoint or a HALT command, and reports completion with a stop reason and the executed-cycle count.
- The design-side counterpart of the cycle-counting bench driver: the controller, not the bench, decides how many cycles the CPU executes.

---
 rtl/run_ctrl.sv | 110 +++++++++++
 tb/tb_run_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run controller: gates the CPU clock-enable for a commanded number of cycles and
// reports why and after how many executed cycles each run stopped.
module run_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       stop_reason,
    output logic [CNT_W-1:0] cycles_run
);

    // Opcodes: 00 NOP, 01 RUN, 10 STEP, 11 HALT.
    localparam logic [1:0] OpRun  = 2'b01;
    localparam logic [1:0] OpStep = 2'b10;
    localparam logic [1:0] OpHalt = 2'b11;

    localparam logic [1:0] ReasonNone  = 2'd0;
    localparam logic [1:0] ReasonCount = 2'd1;
    localparam logic [1:0] ReasonBp    = 2'd2;
    localparam logic [1:0] ReasonHalt  = 2'd3;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] remain_q;
    logic             free_q;
    logic [1:0]       reason_q;
    logic [CNT_W-1:0] cycles_q;

    logic             cmd_fire;
    logic             halt_req;
    logic             bp_hit;
    logic             last_step;
    logic [CNT_W-1:0] cycles_inc;

    always_comb begin
        cmd_ready = (state_q != StDone) && !rst;
        cmd_fire  = cmd_valid && cmd_ready;
        halt_req  = cmd_valid && (cmd_op == OpHalt);
        // cycles_run != 0 lets a run resume from the breakpointed PC
        bp_hit    = bp_en && (pc == bp_addr) && (cycles_q != '0);
        cpu_en    = (state_q == StRun) && !bp_hit && !halt_req && !rst;
        last_step = cpu_en && !free_q && (remain_q == CNT_W'(1));
        cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            remain_q <= '0;
            free_q   <= 1'b0;
            reason_q <= ReasonNone;
            cycles_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_fire && (cmd_op == OpRun || cmd_op == OpStep)) begin
                        state_q  <= StRun;
                        remain_q <= (cmd_op == OpStep) ? CNT_W'(1) : cmd_count;
                        free_q   <= (cmd_op == OpRun) && (cmd_count == '0);
                        cycles_q <= '0;
                        reason_q <= ReasonNone;
                    end
                end
                StRun: begin
                    if (cpu_en) begin
                        cycles_q <= cycles_inc;
                        if (!free_q) begin
                            remain_q <= remain_q - CNT_W'(1);
                        end
                    end
                    // Halt outranks breakpoint, which outranks budget exhaustion
                    if (halt_req) begin
                        state_q  <= StDone;
                        reason_q <= ReasonHalt;
                    end else if (bp_hit) begin
                        state_q  <= StDone;
                        reason_q <= ReasonBp;
                    end else if (last_step) begin
                        state_q  <= StDone;
                        reason_q <= ReasonCount;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign stop_reason = reason_q;
    assign cycles_run  = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed and random runs, expected outcome of each run computed
// from budget / breakpoint distance / halt point and checked by a done-pulse monitor.
module tb_run_ctrl;

    localparam int CW  = 32;
    localparam int PW  = 32;
    localparam int INF = 1 << 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic          bp_en;
    logic [PW-1:0] bp_addr;
    logic [PW-1:0] pc;
    logic          cpu_en;
    logic          busy;
    logic          done;
    logic [1:0]    stop_reason;
    logic [CW-1:0] cycles_run;

    always #5 clk = ~clk;

    run_ctrl #(.CNT_W(CW), .PC_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .busy       (busy),
        .done       (done),
        .stop_reason(stop_reason),
        .cycles_run (cycles_run)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        int reason;
        int cycles;
        int done_cyc;
    } want_t;

    want_t sb[$];

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: counts enabled cycles itself and checks each done pulse against the queue
    int mon_en = 0;
    initial begin
        want_t w;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_en = 0;
            end else begin
                if (cpu_en) mon_en++;
                if (done) begin
                    chk("busy_in_done", busy, 0);
                    chk("ready_in_done", cmd_ready, 0);
                    chk("done_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        w = sb.pop_front();
                        chk("stop_reason", stop_reason, w.reason);
                        chk("cycles_run", cycles_run, w.cycles);
                        chk("en_cycles", mon_en, w.cycles);
                        chk("done_cycle", cyc, w.done_cyc);
                    end
                    mon_en = 0;
                end
            end
        end
    end

    // Bench-side CPU: PC advances by 4 on every enabled edge
    bit en_s;
    int ecnt;

    task automatic tick();
        @(negedge clk);
        en_s = cpu_en;
        @(posedge clk);
        #1;
        if (en_s) begin
            pc = pc + 32'd4;
            ecnt++;
        end
    endtask

    // Issue one run; halt_k = number of enabled cycles before HALT is sent (INF = never)
    task automatic do_run(input logic [1:0] op, input int count, input int halt_k,
                          input int noise_pct);
        int n_eff, d, m, reason;
        bit halt_sent;
        logic [PW-1:0] s;
        want_t w;
        s = pc;
        halt_sent = 0;
        n_eff = (op == 2'b10) ? 1 : ((count == 0) ? INF : count);
        d = INF;
        if (bp_en && bp_addr > s && ((bp_addr - s) % 4 == 0)) d = int'((bp_addr - s) / 4);
        m = n_eff;
        if (d < m) m = d;
        if (halt_k < m) m = halt_k;
        if (halt_k == m && halt_k < n_eff) reason = 3;
        else if (d == m && d < n_eff) reason = 2;
        else reason = 1;

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CW'(count);
        tick();
        cmd_valid = 1'b0;
        ecnt      = 0;
        w.reason   = reason;
        w.cycles   = m;
        w.done_cyc = cyc + m + ((reason == 1) ? 0 : 1);
        sb.push_back(w);

        for (int i = 0; i < m + 2; i++) begin
            cmd_valid = 1'b0;
            if (!halt_sent && ecnt == halt_k && halt_k < n_eff) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'b11;
                halt_sent = 1;
            end else if (ecnt < m && int'($urandom_range(99)) < noise_pct) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom_range(2));
                cmd_count = CW'($urandom_range(20));
            end
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("reason_hold", stop_reason, reason);
        chk("cycles_hold", cycles_run, m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, hk, np;
        logic [1:0] op;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = '0;
        bp_en     = 1'b0;
        bp_addr   = '0;
        pc        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_reason", stop_reason, 0);
        chk("reset_cycles", cycles_run, 0);
        chk("reset_ready", cmd_ready, 1);
        @(posedge clk);
        #1;

        do_run(2'b01, 5, INF, 0);
        repeat (3) do_run(2'b10, 99, INF, 0);

        pc = '0; bp_en = 1'b1; bp_addr = 32'h0000_000C;
        do_run(2'b01, 100, INF, 0);
        do_run(2'b01, 2, INF, 0);

        bp_en = 1'b0;
        do_run(2'b01, 0, 7, 0);

        pc = '0; bp_en = 1'b1; bp_addr = 32'h10;
        do_run(2'b01, 0, 4, 0);

        pc = '0; bp_addr = 32'h14;
        do_run(2'b01, 6, INF, 0);

        bp_en = 1'b0;
        do_run(2'b01, 8, INF, 100);

        // Reset in the third cycle of a 10-cycle run
        pc = '0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 32'd10;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cpu_en", cpu_en, 0);
        chk("midrst_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_cycles", cycles_run, 0);
        chk("midrst_reason", stop_reason, 0);
        chk("midrst_done", done, 0);
        @(posedge clk);
        #1;
        repeat (4) tick();

        for (int r = 0; r < 40; r++) begin
            pc      = PW'($urandom_range(64) * 4);
            op      = ($urandom_range(3) == 0) ? 2'b10 : 2'b01;
            cnt     = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(1, 30));
            bp_en   = 1'($urandom_range(1));
            bp_addr = pc + PW'($urandom_range(20) * 4) + (($urandom_range(7) == 0) ? 32'd2 : 32'd0);
            hk      = ($urandom_range(2) == 0) ? int'($urandom_range(25)) : INF;
            np      = ($urandom_range(1) == 1) ? 30 : 0;
            if (op == 2'b01 && cnt == 0 && hk == INF) hk = int'($urandom_range(30));
            do_run(op, cnt, hk, np);
        end

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
